// File: rtl/spwm_dt_pkg.sv
// Shared constants and helpers for the sine-PWM / dead-time block.
// Fixed-point unity is derived here so every consumer agrees on the scaling.
package spwm_dt_pkg;

  localparam int N_DEF  = 32;
  localparam int Q_DEF  = 28;
  localparam int CH_DEF = 3;
  localparam int DT_DEF = 8;
  localparam int DTW    = 8;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_e;

  function automatic logic signed [63:0] fx_one(input int q);
    return 64'sd1 <<< q;
  endfunction

  function automatic logic signed [63:0] fx_neg_one(input int q);
    return -(64'sd1 <<< q);
  endfunction

endpackage

// File: rtl/spwm_deadtime.sv
// One phase leg: turns a raw comparator bit into non-overlapping hi/lo gates
// that only assert once raw has held steady for DT cycles.
module spwm_deadtime
  import spwm_dt_pkg::*;
#(
  parameter int DT = DT_DEF
) (
  input  logic clk,
  input  logic res,
  input  logic en,
  input  logic raw,
  output logic hi,
  output logic lo
);

  localparam logic [DTW-1:0] DT_L = DTW'(DT);

  logic [DTW-1:0] cnt_q, cnt_d, cnt_eff;
  logic           raw_q, raw_d;
  logic           hi_q, hi_d;
  logic           lo_q, lo_d;

  // A raw edge reloads the count in the same cycle, so DT=0 passes raw straight through.
  always_comb begin
    raw_d   = raw;
    cnt_eff = (raw != raw_q) ? DT_L : cnt_q;
    cnt_d   = DT_L;
    hi_d    = 1'b0;
    lo_d    = 1'b0;
    if (en) begin
      if (cnt_eff == '0) begin
        cnt_d = '0;
        hi_d  = raw;
        lo_d  = ~raw;
      end else begin
        cnt_d = cnt_eff - DTW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      cnt_q <= DT_L;
      raw_q <= 1'b0;
      hi_q  <= 1'b0;
      lo_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      raw_q <= raw_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: rtl/spwm_dt.sv
// Triangle-carrier sine PWM with double-buffered references (swapped at the
// valley) and per-leg dead-time insertion.
module spwm_dt
  import spwm_dt_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int Q  = Q_DEF,
  parameter int CH = CH_DEF,
  parameter int DT = DT_DEF
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  en,
  input  logic [N-1:0]          step,
  input  logic [CH*N-1:0]       ref_in,
  input  logic                  ref_wr,
  output logic [CH-1:0]         hi,
  output logic [CH-1:0]         lo,
  output logic signed [N-1:0]   carrier,
  output logic                  peak,
  output logic                  valley
);

  // Two guard bits: an unsigned N-bit step added to a value near ONE cannot wrap.
  localparam int AW = N + 2;
  localparam logic signed [AW-1:0] ONE_X     = AW'(fx_one(Q));
  localparam logic signed [AW-1:0] NEG_ONE_X = AW'(fx_neg_one(Q));
  localparam logic signed [N-1:0]  ONE_N     = ONE_X[N-1:0];
  localparam logic signed [N-1:0]  NEG_ONE_N = NEG_ONE_X[N-1:0];

  logic signed [N-1:0]     carrier_q, carrier_d;
  dir_e                    dir_q, dir_d;
  logic                    peak_q, peak_d;
  logic                    valley_q, valley_d;
  logic [CH-1:0][N-1:0]    act_q, act_d;
  logic [CH-1:0][N-1:0]    pend_q, pend_d;
  logic                    pflag_q, pflag_d;

  logic signed [AW-1:0]    car_x, step_x, sum_up, sum_dn;
  logic [CH-1:0]           raw;

  assign car_x  = {{2{carrier_q[N-1]}}, carrier_q};
  assign step_x = {2'b00, step};
  assign sum_up = car_x + step_x;
  assign sum_dn = car_x - step_x;

  always_comb begin
    carrier_d = carrier_q;
    dir_d     = dir_q;
    peak_d    = 1'b0;
    valley_d  = 1'b0;
    if (step != '0) begin
      if (dir_q == DIR_UP) begin
        if (sum_up >= ONE_X) begin
          carrier_d = ONE_N;
          dir_d     = DIR_DN;
          peak_d    = 1'b1;
        end else begin
          carrier_d = sum_up[N-1:0];
        end
      end else begin
        if (sum_dn <= NEG_ONE_X) begin
          carrier_d = NEG_ONE_N;
          dir_d     = DIR_UP;
          valley_d  = 1'b1;
        end else begin
          carrier_d = sum_dn[N-1:0];
        end
      end
    end
  end

  // Active refs only change at the valley; a same-cycle write still lands in pending.
  always_comb begin
    act_d   = act_q;
    pend_d  = pend_q;
    pflag_d = pflag_q;
    if (valley_q && pflag_q) begin
      act_d   = pend_q;
      pflag_d = 1'b0;
    end
    if (ref_wr) begin
      pend_d  = ref_in;
      pflag_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      carrier_q <= '0;
      dir_q     <= DIR_UP;
      peak_q    <= 1'b0;
      valley_q  <= 1'b0;
      act_q     <= '0;
      pend_q    <= '0;
      pflag_q   <= 1'b0;
    end else begin
      carrier_q <= carrier_d;
      dir_q     <= dir_d;
      peak_q    <= peak_d;
      valley_q  <= valley_d;
      act_q     <= act_d;
      pend_q    <= pend_d;
      pflag_q   <= pflag_d;
    end
  end

  // Out-of-range references saturate naturally since the carrier never leaves [-ONE, ONE].
  always_comb begin
    raw = '0;
    for (int i = 0; i < CH; i++) begin
      raw[i] = $signed(act_q[i]) >= carrier_q;
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_leg
    spwm_deadtime #(.DT(DT)) u_dt (
      .clk (clk),
      .res (res),
      .en  (en),
      .raw (raw[i]),
      .hi  (hi[i]),
      .lo  (lo[i])
    );
  end

  assign carrier = carrier_q;
  assign peak    = peak_q;
  assign valley  = valley_q;

endmodule

// File: tb/tb_spwm_dt.sv
// Scoreboard bench: a cycle-level arithmetic model predicts every output,
// a separate monitor pops predictions and compares against the DUT.
module tb_spwm_dt;

  localparam int N  = 32;
  localparam int Q  = 28;
  localparam int CH = 3;
  localparam int DT = 4;
  localparam longint ONE = 64'sd1 <<< Q;

  logic                clk = 1'b0;
  logic                res, en, ref_wr;
  logic [N-1:0]        step;
  logic [CH*N-1:0]     ref_in;
  logic [CH-1:0]       hi, lo;
  logic signed [N-1:0] carrier;
  logic                peak, valley;

  always #5 clk = ~clk;

  spwm_dt #(.N(N), .Q(Q), .CH(CH), .DT(DT)) dut (
    .clk(clk), .res(res), .en(en), .step(step), .ref_in(ref_in), .ref_wr(ref_wr),
    .hi(hi), .lo(lo), .carrier(carrier), .peak(peak), .valley(valley)
  );

  typedef struct {
    longint        car;
    bit            pk;
    bit            vl;
    bit [CH-1:0]   hi;
    bit [CH-1:0]   lo;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad   = 0;

  // reference model state
  longint m_car;
  bit     m_up, m_pk, m_vl, m_pf;
  longint m_act[CH];
  longint m_pend[CH];
  bit     h_ok[$];
  bit     h_raw[CH][$];

  task automatic check(input string name, input longint got, input longint want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, got, want, $time);
    end
  endtask

  // Called at each rising edge: inputs are the values held during the ending cycle.
  task automatic model_edge();
    exp_t   e;
    bit     r[CH];
    bit     stable;
    bit     vl_now;
    longint s;
    for (int i = 0; i < CH; i++) r[i] = (m_act[i] >= m_car);
    h_ok.push_back(en && !res);
    for (int i = 0; i < CH; i++) h_raw[i].push_back(r[i]);
    if (h_ok.size() > DT + 1) begin
      void'(h_ok.pop_front());
      for (int i = 0; i < CH; i++) void'(h_raw[i].pop_front());
    end
    // a gate drives only when enabled and raw unchanged over the last DT+1 cycles
    for (int i = 0; i < CH; i++) begin
      stable = (h_ok.size() == DT + 1);
      foreach (h_ok[k]) if (!h_ok[k] || h_raw[i][k] != r[i]) stable = 0;
      e.hi[i] = stable && r[i];
      e.lo[i] = stable && !r[i];
    end
    if (res) begin
      m_car = 0; m_up = 1; m_pk = 0; m_vl = 0; m_pf = 0;
      for (int i = 0; i < CH; i++) begin m_act[i] = 0; m_pend[i] = 0; end
    end else begin
      vl_now = m_vl;
      s = longint'(step);
      m_pk = 0; m_vl = 0;
      if (s != 0) begin
        if (m_up) begin
          if (m_car + s >= ONE) begin m_car = ONE; m_up = 0; m_pk = 1; end
          else m_car = m_car + s;
        end else begin
          if (m_car - s <= -ONE) begin m_car = -ONE; m_up = 1; m_vl = 1; end
          else m_car = m_car - s;
        end
      end
      if (vl_now && m_pf) begin
        for (int i = 0; i < CH; i++) m_act[i] = m_pend[i];
        m_pf = 0;
      end
      if (ref_wr) begin
        for (int i = 0; i < CH; i++) m_pend[i] = longint'($signed(ref_in[i*N +: N]));
        m_pf = 1;
      end
    end
    e.car = m_car; e.pk = m_pk; e.vl = m_vl;
    sbq.push_back(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
      ref_wr = 1'b0;
    end
  endtask

  task automatic set_refs(input logic [N-1:0] r0, input logic [N-1:0] r1, input logic [N-1:0] r2);
    ref_in[0*N +: N] = r0;
    ref_in[1*N +: N] = r1;
    ref_in[2*N +: N] = r2;
    ref_wr = 1'b1;
  endtask

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("carrier", longint'(carrier), e.car);
        check("peak",    longint'(peak),    longint'(e.pk));
        check("valley",  longint'(valley),  longint'(e.vl));
        check("hi",      longint'(hi),      longint'(e.hi));
        check("lo",      longint'(lo),      longint'(e.lo));
        check("hi_and_lo_overlap", longint'(hi & lo), 0);
      end
    end
  end

  initial begin
    int     wait_cnt;
    longint v;
    logic [N-1:0] rv [CH];
    res = 1'b1; en = 1'b1; ref_wr = 1'b0; step = 32'h0100_0000; ref_in = '0;
    cyc(3);
    res = 1'b0;
    // carrier should hit +ONE with a peak 16 edges after release
    cyc(16);
    @(negedge clk);
    check("first_peak_carrier", longint'(carrier), ONE);
    check("first_peak_pulse", longint'(peak), 1);
    cyc(140);

    // new ch0 reference written mid up-slope; takes effect at the next valley
    cyc(10);
    set_refs(32'h0800_0000, 32'h0, 32'h0);
    cyc(200);

    // saturating references: ch0 always hi, ch1 always lo
    set_refs(32'h1800_0000, 32'hE800_0000, 32'h0000_0000);
    cyc(200);

    // enable drop, then a one-cycle reset mid-slope
    cyc(7);
    en = 1'b0;
    cyc(10);
    res = 1'b1;
    cyc(1);
    res = 1'b0; en = 1'b1;
    cyc(60);

    // carrier alternates +/-ONE every cycle: raw toggles too fast for dead-time
    set_refs(32'h0, 32'h0400_0000, 32'hFC00_0000);
    step = 32'h2000_0000;
    cyc(150);
    step = 32'h1000_0000;
    cyc(80);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 49) == 0) begin
        case ($urandom_range(0, 9))
          0: step = '0;
          1: step = 32'h2000_0000;
          2: step = 32'hFFFF_FFFF;
          3: step = 32'h1000_0000;
          default: step = 32'($urandom_range(1, 32'h0400_0000));
        endcase
      end
      if ($urandom_range(0, 19) == 0) begin
        for (int i = 0; i < CH; i++) begin
          if ($urandom_range(0, 3) == 0) rv[i] = $urandom;
          else begin
            v = longint'($urandom_range(0, 32'h2000_0000)) - ONE;
            rv[i] = v[N-1:0];
          end
        end
        set_refs(rv[0], rv[1], rv[2]);
      end
      if ($urandom_range(0, 59) == 0) en = ~en;
      res = ($urandom_range(0, 299) == 0);
      cyc(1);
    end
    res = 1'b0; en = 1'b1;
    cyc(5);

    wait_cnt = 0;
    while (sbq.size() > 0 && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    total++;
    if (sbq.size() > 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", sbq.size());
    end
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
